// File: rtl/cmn_iter_divider.sv
// cmn_iter_divider: iterative restoring unsigned divider, one quotient bit per cycle, val/rdy on both sides
module cmn_iter_divider #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [p_nbits-1:0] recv_dividend,
  input  logic [p_nbits-1:0] recv_divisor,
  input  logic               recv_val,
  output logic               recv_rdy,
  output logic [p_nbits-1:0] send_quotient,
  output logic [p_nbits-1:0] send_remainder,
  output logic               send_div_by_zero,
  output logic               send_val,
  input  logic               send_rdy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int cw = $clog2(p_nbits + 1);
  state_t state;
  logic [cw-1:0] cnt;
  logic [p_nbits-1:0] rem, quo, dvs;
  logic [p_nbits:0] sh, trial;
  logic dz;
  // rem stays below the divisor, so the shifted partial remainder fits in p_nbits+1 bits
  // and the MSB of the trial difference is the borrow
  always_comb begin
    sh = {rem, quo[p_nbits-1]};
    trial = sh - {1'b0, dvs};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      dz <= 1'b0;
    end else begin
      case (state)
        IDLE: if (recv_val) begin
          dvs <= recv_divisor;
          if (recv_divisor == '0) begin
            quo <= '1;
            rem <= recv_dividend;
            dz <= 1'b1;
            state <= DONE;
          end else begin
            quo <= recv_dividend;
            rem <= '0;
            cnt <= cw'(p_nbits);
            state <= CALC;
          end
        end
        CALC: begin
          rem <= trial[p_nbits] ? sh[p_nbits-1:0] : trial[p_nbits-1:0];
          quo <= {quo[p_nbits-2:0], ~trial[p_nbits]};
          cnt <= cnt - 1'b1;
          if (cnt == cw'(1)) state <= DONE;
        end
        DONE: if (send_rdy) begin
          dz <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign recv_rdy = state == IDLE;
  assign send_val = state == DONE;
  assign send_quotient = quo;
  assign send_remainder = rem;
  assign send_div_by_zero = dz;
endmodule

// File: tb/tb_cmn_iter_divider.sv
// tb_cmn_iter_divider: directed and random checks of 32-bit and 8-bit dividers against an arithmetic model
module tb_cmn_iter_divider;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic rv = 1'b0, srdy = 1'b1, sel8 = 1'b0;
  logic rrdy32, sval32, dz32, rrdy8, sval8, dz8;
  logic [31:0] q32, r32;
  logic [7:0] q8, r8;
  logic [31:0] o_q, o_r;
  logic o_rrdy, o_sval, o_dz;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  cmn_iter_divider #(.p_nbits(32)) dut32 (
    .clk(clk), .reset(reset), .recv_dividend(dividend), .recv_divisor(divisor),
    .recv_val(rv && !sel8), .recv_rdy(rrdy32), .send_quotient(q32), .send_remainder(r32),
    .send_div_by_zero(dz32), .send_val(sval32), .send_rdy(srdy)
  );
  cmn_iter_divider #(.p_nbits(8)) dut8 (
    .clk(clk), .reset(reset), .recv_dividend(dividend[7:0]), .recv_divisor(divisor[7:0]),
    .recv_val(rv && sel8), .recv_rdy(rrdy8), .send_quotient(q8), .send_remainder(r8),
    .send_div_by_zero(dz8), .send_val(sval8), .send_rdy(srdy)
  );

  assign o_q = sel8 ? {24'b0, q8} : q32;
  assign o_r = sel8 ? {24'b0, r8} : r32;
  assign o_rrdy = sel8 ? rrdy8 : rrdy32;
  assign o_sval = sel8 ? sval8 : sval32;
  assign o_dz = sel8 ? dz8 : dz32;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    if (b == 0) begin
      q = sel8 ? 32'hFF : 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic wait_resp(input int exp_lat, input string tag);
    int cyc = 0;
    int rdy_seen = 0;
    while (!o_sval && cyc < 100) begin
      if (o_rrdy) rdy_seen++;
      step();
      cyc++;
    end
    chk({tag, "_lat"}, cyc, exp_lat);
    chk({tag, "_rdy_low"}, rdy_seen, 0);
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input int stall, input string tag);
    logic [31:0] eq, er;
    int g = 0;
    model(a, b, eq, er);
    while (!o_rrdy && g < 100) begin
      step();
      g++;
    end
    chk({tag, "_rdy"}, {31'b0, o_rrdy}, 1);
    dividend = a;
    divisor = b;
    rv = 1'b1;
    srdy = (stall == 0);
    step();
    rv = 1'b0;
    wait_resp(b == 0 ? 0 : (sel8 ? 8 : 32), tag);
    chk({tag, "_q"}, o_q, eq);
    chk({tag, "_r"}, o_r, er);
    chk({tag, "_dz"}, {31'b0, o_dz}, {31'b0, b == 0});
    if (!sel8 && b != 0) chk({tag, "_inv"}, o_q * b + o_r, a);
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, "_stall_val"}, {31'b0, o_sval}, 1);
      chk({tag, "_stall_q"}, o_q, eq);
      chk({tag, "_stall_r"}, o_r, er);
    end
    srdy = 1'b1;
    step();
    chk({tag, "_post_val"}, {31'b0, o_sval}, 0);
    chk({tag, "_post_rdy"}, {31'b0, o_rrdy}, 1);
  endtask

  initial begin
    int spurious;
    logic [31:0] a, b;
    step();
    for (int s = 0; s < 2; s++) begin
      sel8 = s[0];
      #1;
      chk("rst_rdy", {31'b0, o_rrdy}, 1);
      chk("rst_val", {31'b0, o_sval}, 0);
      chk("rst_q", o_q, 0);
      chk("rst_r", o_r, 0);
      chk("rst_dz", {31'b0, o_dz}, 0);
    end
    sel8 = 1'b0;
    reset = 1'b1;
    step();
    op(100, 7, 0, "d100_7");
    // back-to-back with recv_val held: second request must wait for IDLE
    dividend = 32'hFFFF_FFFF;
    divisor = 1;
    rv = 1'b1;
    srdy = 1'b1;
    step();
    dividend = 5;
    divisor = 9;
    wait_resp(32, "b2b_a");
    chk("b2b_a_q", o_q, 32'hFFFF_FFFF);
    chk("b2b_a_r", o_r, 0);
    chk("b2b_a_rdy", {31'b0, o_rrdy}, 0);
    step();
    chk("b2b_idle_val", {31'b0, o_sval}, 0);
    chk("b2b_idle_rdy", {31'b0, o_rrdy}, 1);
    step();
    chk("b2b_b_acc", {31'b0, o_rrdy}, 0);
    rv = 1'b0;
    wait_resp(32, "b2b_b");
    chk("b2b_b_q", o_q, 0);
    chk("b2b_b_r", o_r, 5);
    step();
    op(1234, 0, 0, "dz1234");
    op(10, 3, 0, "d10_3");
    op(1000, 33, 5, "stall1000_33");
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "max");
    op(0, 5, 0, "zero_dividend");
    op(6, 100, 0, "small_dividend");
    // reset mid-calculation abandons the operation
    dividend = 32'hDEAD_BEEF;
    divisor = 3;
    rv = 1'b1;
    step();
    rv = 1'b0;
    repeat (16) step();
    reset = 1'b0;
    #1;
    chk("midrst_rdy", {31'b0, o_rrdy}, 1);
    chk("midrst_val", {31'b0, o_sval}, 0);
    chk("midrst_q", o_q, 0);
    chk("midrst_r", o_r, 0);
    chk("midrst_dz", {31'b0, o_dz}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_sval) spurious++;
    end
    chk("midrst_spurious", spurious, 0);
    op(77, 7, 0, "d77_7");
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = (i % 4 == 0) ? $urandom_range(1, 255) : $urandom;
      op(a, b, i % 3, "rnd32");
    end
    sel8 = 1'b1;
    op(255, 16, 0, "n8_255_16");
    op(200, 200, 0, "n8_200_200");
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      op(a, b, 0, "rnd8");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
